// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with single-outstanding imem requests, one-entry skid buffer and IF/ID register
module fetch_unit #(
  parameter int PC_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stallF,
  input  logic                   stallD,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirectPc,
  output logic                   imemReq,
  output logic [PC_WIDTH-1:0]    imemAddr,
  input  logic                   imemGnt,
  input  logic                   imemRvalid,
  input  logic [INSTR_WIDTH-1:0] imemRdata,
  output logic [INSTR_WIDTH-1:0] instrD,
  output logic [PC_WIDTH-1:0]    pcD,
  output logic [PC_WIDTH-1:0]    pcPlus4D,
  output logic                   validD
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DROP} state_t;
  state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d, skid_pc_q, skid_pc_d;
  logic [PC_WIDTH-1:0] pcd_q, pcd_d, pcp4_q, pcp4_d, ld_pc;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d, instr_q, instr_d, ld_instr;
  logic valid_q, valid_d, fire, free, load_mem, load_skid, store, load;
  always_comb begin
    imemReq = (state_q == S_REQ) & ~stallF & ~redirect & ~reset;
    fire = imemReq & imemGnt;
    free = ~valid_q | ~stallD;
    load_mem = (state_q == S_WAIT) & imemRvalid & free & ~redirect;
    load_skid = (state_q == S_FULL) & ~stallD & ~redirect;
    store = (state_q == S_WAIT) & imemRvalid & ~free & ~redirect;
    load = load_mem | load_skid;
    ld_instr = load_skid ? skid_instr_q : imemRdata;
    ld_pc = load_skid ? skid_pc_q : req_pc_q;
    instr_d = load ? ld_instr : instr_q;
    pcd_d = load ? ld_pc : pcd_q;
    pcp4_d = load ? ld_pc + PC_WIDTH'(4) : pcp4_q;
    valid_d = ~redirect & (load | (valid_q & stallD));
    pc_d = redirect ? (redirectPc & ~PC_WIDTH'(3)) : fire ? pc_q + PC_WIDTH'(4) : pc_q;
    req_pc_d = fire ? pc_q : req_pc_q;
    skid_instr_d = store ? imemRdata : skid_instr_q;
    skid_pc_d = store ? req_pc_q : skid_pc_q;
    state_d = state_q;
    case (state_q)
      S_REQ:  state_d = fire ? S_WAIT : S_REQ;
      S_WAIT: state_d = imemRvalid ? ((redirect | free) ? S_REQ : S_FULL) : (redirect ? S_DROP : S_WAIT);
      S_FULL: state_d = (redirect | ~stallD) ? S_REQ : S_FULL;
      S_DROP: state_d = imemRvalid ? S_REQ : S_DROP;
      default: state_d = S_REQ;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q <= RESET_PC;
      req_pc_q <= '0;
      skid_pc_q <= '0;
      skid_instr_q <= '0;
      instr_q <= '0;
      pcd_q <= '0;
      pcp4_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      skid_pc_q <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      instr_q <= instr_d;
      pcd_q <= pcd_d;
      pcp4_q <= pcp4_d;
      valid_q <= valid_d;
    end
  end
  assign imemAddr = pc_q;
  assign instrD = instr_q;
  assign pcD = pcd_q;
  assign pcPlus4D = pcp4_q;
  assign validD = valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based fetch model checked every cycle
module tb_fetch_unit;
  logic clk = 0, reset = 1, stallF = 0, stallD = 0, redirect = 0, imemGnt = 0, imemRvalid = 0;
  logic [31:0] redirectPc = 0, imemRdata = 0;
  logic imemReq, validD;
  logic [31:0] imemAddr, instrD, pcD, pcPlus4D;
  int n_chk = 0, n_fail = 0;
  int mem_cnt = 0, lat = 1;
  logic [31:0] mem_addr = 0;
  logic [31:0] m_pc, m_opc, m_instr, m_pcd, m_pp4;
  bit m_out, m_drop, m_v;
  logic [63:0] m_skid[$];
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .redirect(redirect),
    .redirectPc(redirectPc), .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
    .imemRvalid(imemRvalid), .imemRdata(imemRdata), .instrD(instrD), .pcD(pcD),
    .pcPlus4D(pcPlus4D), .validD(validD)
  );
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'hA + (a >> 2);
  endfunction
  function automatic bit m_req();
    return !m_out && !m_drop && m_skid.size() == 0 && !stallF && !redirect && !reset;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    bit fire, ld;
    logic [63:0] e;
    fire = m_req() && imemGnt;
    ld = 0;
    e = '0;
    if (mem_cnt > 0) mem_cnt--;
    if (fire) begin
      mem_cnt = lat;
      mem_addr = m_pc;
    end
    if (reset) begin
      m_pc = 0; m_opc = 0; m_out = 0; m_drop = 0; m_skid.delete();
      m_v = 0; m_instr = 0; m_pcd = 0; m_pp4 = 0;
    end else if (redirect) begin
      m_v = 0;
      m_skid.delete();
      m_pc = redirectPc & ~32'h3;
      if (m_out) begin
        m_drop = !imemRvalid;
        m_out = 0;
      end else if (m_drop && imemRvalid) m_drop = 0;
    end else begin
      if (m_skid.size() != 0 && !stallD) begin
        e = m_skid.pop_front();
        ld = 1;
      end else if (m_out && imemRvalid) begin
        m_out = 0;
        e = {imemRdata, m_opc};
        if (!m_v || !stallD) ld = 1;
        else m_skid.push_back(e);
      end else if (m_drop && imemRvalid) m_drop = 0;
      if (ld) begin
        m_instr = e[63:32];
        m_pcd = e[31:0];
        m_pp4 = e[31:0] + 32'd4;
        m_v = 1;
      end else if (!stallD) m_v = 0;
      if (fire) begin
        m_out = 1;
        m_opc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
  end
  always @(negedge clk) begin
    #1;
    if (reset) begin
      chk("rst_imemReq", {31'b0, imemReq}, 32'h0);
      chk("rst_imemAddr", imemAddr, 32'h0);
      chk("rst_validD", {31'b0, validD}, 32'h0);
      chk("rst_instrD", instrD, 32'h0);
      chk("rst_pcD", pcD, 32'h0);
      chk("rst_pcPlus4D", pcPlus4D, 32'h0);
    end else begin
      chk("imemReq", {31'b0, imemReq}, {31'b0, m_req()});
      chk("imemAddr", imemAddr, m_pc);
      chk("validD", {31'b0, validD}, {31'b0, m_v});
      chk("instrD", instrD, m_instr);
      chk("pcD", pcD, m_pcd);
      chk("pcPlus4D", pcPlus4D, m_pp4);
    end
  end
  task automatic cyc(input bit rs, input bit sf, input bit sd, input bit rd,
                     input logic [31:0] rpc, input bit g, input bit sp);
    @(negedge clk);
    reset = rs;
    stallF = sf;
    stallD = sd;
    redirect = rd;
    redirectPc = rpc;
    imemGnt = g;
    imemRvalid = (mem_cnt == 1) || sp;
    imemRdata = sp ? 32'h5555_5555 : (mem_cnt == 1) ? mem_data(mem_addr) : 32'hDEAD_BEEF;
  endtask
  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk({"pin_", nm}, act, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 0);
    #2;
    pin("t1_instrA", instrD, 32'hA);
    pin("t1_pcD0", pcD, 32'h0);
    pin("t1_pp4_4", pcPlus4D, 32'h4);
    pin("t1_valid", {31'b0, validD}, 32'h1);
    pin("t1_addr4", imemAddr, 32'h4);
    cyc(0, 0, 0, 0, 0, 1, 0);
    pin("t1_bubble", {31'b0, validD}, 32'h0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    #2;
    pin("t1_instrB", instrD, 32'hB);
    pin("t1_pcD4", pcD, 32'h4);
    pin("t1_pp4_8", pcPlus4D, 32'h8);
    repeat (3) cyc(0, 0, 1, 0, 0, 1, 0);
    #2;
    pin("t2_noreq", {31'b0, imemReq}, 32'h0);
    pin("t2_hold_pcD", pcD, 32'h4);
    pin("t2_hold_valid", {31'b0, validD}, 32'h1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    lat = 2;
    #2;
    pin("t2_skid_pcD", pcD, 32'h8);
    pin("t2_skid_instr", instrD, 32'hC);
    pin("t2_skid_pp4", pcPlus4D, 32'hC);
    cyc(0, 0, 0, 1, 32'h103, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    lat = 1;
    #2;
    pin("t3_drop_valid", {31'b0, validD}, 32'h0);
    pin("t3_drop_noreq", {31'b0, imemReq}, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    #2;
    pin("t3_addr100", imemAddr, 32'h100);
    pin("t3_req", {31'b0, imemReq}, 32'h1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 32'h200, 1, 0);
    #2;
    pin("t4_pre_valid", {31'b0, validD}, 32'h1);
    pin("t4_pre_pcD", pcD, 32'h100);
    pin("t4_pre_instr", instrD, 32'h4A);
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0);
    #2;
    pin("t4_valid0", {31'b0, validD}, 32'h0);
    pin("t4_pcF", imemAddr, 32'h200);
    cyc(0, 0, 0, 0, 0, 1, 0);
    #2;
    pin("t5_addr", imemAddr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    lat = 3;
    #2;
    pin("t5_pcD", pcD, 32'hFFFF_FFFC);
    pin("t5_pp4_wrap", pcPlus4D, 32'h0);
    pin("t5_instr", instrD, 32'h4000_0009);
    pin("t5_addr_wrap", imemAddr, 32'h0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    #2;
    pin("t6_valid", {31'b0, validD}, 32'h0);
    pin("t6_req", {31'b0, imemReq}, 32'h0);
    pin("t6_pcD", pcD, 32'h0);
    pin("t6_addr", imemAddr, 32'h0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    #2;
    pin("t6_late_rvalid", {31'b0, imemRvalid}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    lat = 1;
    #2;
    pin("t6_ignored_valid", {31'b0, validD}, 32'h0);
    pin("t6_req_again", {31'b0, imemReq}, 32'h1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    pin("t6_spur_valid", {31'b0, validD}, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    #2;
    pin("t6_refetch_pcD", pcD, 32'h0);
    pin("t6_refetch_instr", instrD, 32'hA);
    pin("stallF_noreq", {31'b0, imemReq}, 32'h0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
